// File: rtl/crc_stream_gen_pkg.sv
// rtl/crc_stream_gen_pkg.sv - shared types, defaults and the unrolled CRC bit update
package crc_stream_pkg;

  typedef enum logic [1:0] {IDLE, DATA, APPEND} state_t;

  localparam int CRC_W_DEF  = 24;
  localparam int DATA_W_DEF = 8;
  localparam int N_APP      = CRC_W_DEF / DATA_W_DEF;
  localparam int MAX_W      = 64;

  // Register and data are left-aligned so the feedback tap is always bit MAX_W-1.
  function automatic logic [MAX_W-1:0] crc_step(input logic [MAX_W-1:0] crc,
                                                input logic [MAX_W-1:0] data,
                                                input logic [MAX_W-1:0] poly,
                                                input int crc_w,
                                                input int data_w);
    logic [MAX_W-1:0] c;
    logic [MAX_W-1:0] d;
    logic [MAX_W-1:0] p;
    logic             fb;
    c = crc << (MAX_W - crc_w);
    d = data << (MAX_W - data_w);
    p = poly << (MAX_W - crc_w);
    for (int i = 0; i < MAX_W; i++) begin
      if (i < data_w) begin
        fb = c[MAX_W-1] ^ d[MAX_W-1];
        c  = (c << 1) ^ (fb ? p : '0);
        d  = d << 1;
      end
    end
    return c >> (MAX_W - crc_w);
  endfunction

endpackage

// File: rtl/crc_stream_gen_if.sv
// rtl/crc_stream_gen_if.sv - input/output byte stream bundle for crc_stream_gen
interface crc_stream_gen_if
  import crc_stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic              mode_chk;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  modport master (
    output mode_chk, s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  mode_chk, s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/crc_stream_gen_out_reg.sv
// rtl/crc_stream_gen_out_reg.sv - single-entry valid/ready output register
module crc_out_reg
  import crc_stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              m_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              slot_free
);

  assign slot_free = !m_valid || m_ready;

  // Data and last only move when the slot is free, so a stalled beat holds.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else if (slot_free) begin
      m_valid <= load;
      if (load) begin
        m_data <= load_data;
        m_last <= load_last;
      end
    end
  end

endmodule

// File: rtl/crc_stream_gen.sv
// rtl/crc_stream_gen.sv - inline CRC generator/checker on a valid/ready beat stream
module crc_stream_gen
  import crc_stream_pkg::*;
#(
  parameter int              CRC_W   = CRC_W_DEF,
  parameter logic [CRC_W-1:0] POLY    = 24'h864CFB,
  parameter int              DATA_W  = DATA_W_DEF,
  parameter logic [CRC_W-1:0] INIT    = '0,
  parameter logic [CRC_W-1:0] XOR_OUT = '0,
  parameter logic [CRC_W-1:0] RESIDUE = '0
) (
  input  logic             clk,
  input  logic             rstn,
  crc_stream_gen_if.slave  bus,
  output logic             done,
  output logic             crc_ok,
  output logic [CRC_W-1:0] crc_value
);

  localparam int               APP_N    = CRC_W / DATA_W;
  localparam int               CNT_W    = $clog2(APP_N + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(APP_N - 1);

  state_t            state;
  logic [CRC_W-1:0]  crc;
  logic [CRC_W-1:0]  crc_next;
  logic [CRC_W-1:0]  crc_fin;
  logic [CRC_W-1:0]  crc_sh;
  logic [CNT_W-1:0]  cnt;
  logic              mode_r;
  logic              mode_eff;
  logic              slot_free;
  logic              acc;
  logic              ld;
  logic              ld_last;
  logic [DATA_W-1:0] ld_data;

  assign bus.s_ready = ((state == IDLE) || (state == DATA)) && slot_free;
  assign acc         = bus.s_valid && bus.s_ready;

  always_comb begin
    crc_next = CRC_W'(crc_step(MAX_W'(crc), MAX_W'(bus.s_data), MAX_W'(POLY), CRC_W, DATA_W));
    crc_fin  = crc ^ XOR_OUT;
    crc_sh   = crc_fin >> (DATA_W * (APP_N - 1 - int'(cnt)));
    mode_eff = (state == IDLE) ? bus.mode_chk : mode_r;
    ld       = acc || ((state == APPEND) && slot_free);
    ld_data  = bus.s_data;
    ld_last  = bus.s_last && mode_eff;
    if (state == APPEND) begin
      ld_data = crc_sh[DATA_W-1:0];
      ld_last = (cnt == CNT_LAST);
    end
  end

  crc_out_reg #(.DATA_W(DATA_W)) u_out (
    .clk       (clk),
    .rstn      (rstn),
    .load      (ld),
    .load_data (ld_data),
    .load_last (ld_last),
    .m_ready   (bus.m_ready),
    .m_valid   (bus.m_valid),
    .m_data    (bus.m_data),
    .m_last    (bus.m_last),
    .slot_free (slot_free)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      crc       <= INIT;
      cnt       <= '0;
      mode_r    <= 1'b0;
      done      <= 1'b0;
      crc_ok    <= 1'b0;
      crc_value <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DATA: begin
          if (acc) begin
            crc <= crc_next;
            if (state == IDLE) mode_r <= bus.mode_chk;
            if (!bus.s_last) begin
              state <= DATA;
            end else if (mode_eff) begin
              done      <= 1'b1;
              crc_ok    <= (crc_next == RESIDUE);
              crc_value <= crc_next;
              crc       <= INIT;
              state     <= IDLE;
            end else begin
              cnt   <= '0;
              state <= APPEND;
            end
          end
        end
        APPEND: begin
          if (slot_free) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              done      <= 1'b1;
              crc_ok    <= 1'b1;
              crc_value <= crc_fin;
              crc       <= INIT;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/crc_stream_gen.md
Name: crc_stream_gen

Overview:
- Parametrised, beat-parallel successor to the team's fixed CRC-24 serial transmitter.
- Sits inline on a valid/ready byte stream and supports two modes, selected per frame:
  - Generate: passes each frame through unchanged, then appends the computed CRC as trailing beats.
  - Check: passes the frame through unchanged and flags whether the trailing CRC beats were correct.

Parameters:
- CRC_W, 24, CRC width in bits.
- POLY, 24'h864CFB, generator polynomial without the implicit x^CRC_W term (D^24+D^23+D^18+...+D+1).
- DATA_W, 8, data bits per beat. Must satisfy CRC_W % DATA_W == 0 and DATA_W <= CRC_W.
- INIT, 0, CRC register value at frame start.
- XOR_OUT, 0, XOR applied to the final CRC before it is appended or reported.
- RESIDUE, 0, expected register value after a correct frame plus its CRC in check mode.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- mode_chk  in  1  0=generate, 1=check; sampled with the first beat of each frame
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid && s_ready
- s_data  in  DATA_W  input beat
- s_last  in  1  last beat of input frame
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream ready
- m_data  out  DATA_W  output beat
- m_last  out  1  last beat of output frame
- done  out  1  one-cycle pulse at end of frame
- crc_ok  out  1  check result; valid while done=1, held until next done
- crc_value  out  CRC_W  final CRC (after XOR_OUT in generate, raw register in check); updated with done

Behaviour:
- Reset (rstn=0 at posedge):
  - State goes to IDLE; CRC register loads INIT.
  - m_valid, m_last, done, crc_ok = 0; crc_value = 0; m_data = 0.
  - Any in-flight frame is dropped, including reset mid-frame or mid-append.
- Bit update, for each bit b, MSB of beat first:
  - fb = crc[CRC_W-1] ^ b
  - crc = (crc << 1) ^ (fb ? POLY : 0)
  - DATA_W bit steps are unrolled combinationally per beat.
- Output stage is a single register. A slot is free when !m_valid || m_ready.
- s_ready = (state==IDLE || state==DATA) && slot free. It is never asserted in APPEND.
- Accepted beats appear on m_data exactly 1 cycle later, unmodified; throughput is 1 beat/cycle.
- FSM states: IDLE, DATA, APPEND.
- IDLE:
  - On an accepted beat: latch mode_chk, compute the CRC from INIT over the beat, and load the output register.
  - If s_last=1, handle the frame end immediately (see next bullet). Otherwise go to DATA.
- DATA: each accepted beat updates the CRC. On an accepted beat with s_last=1:
  - Generate mode: go to APPEND; the frame's final data beat has m_last=0.
  - Check mode: m_last=1 on that beat; done pulses the following cycle; crc_ok = (crc==RESIDUE); crc_value = crc; go to IDLE.
- APPEND (generate mode only):
  - Emits CRC_W/DATA_W beats of (crc ^ XOR_OUT), most significant DATA_W slice first.
  - A counter advances only when the slot is free; m_last=1 on the final slice.
  - When the final slice is loaded into the output register: done pulses the next cycle, crc_value is updated, crc_ok=1, and state returns to IDLE.
- CRC register reloads INIT when returning to IDLE.
- mode_chk changes mid-frame are ignored.
- Backpressure: while m_valid && !m_ready, m_data, m_last and the APPEND counter hold; no beat is lost or duplicated.
- Single-beat frames (s_last on the first beat) are legal in both modes.
- In check mode, a frame shorter than CRC_W/DATA_W beats is still processed; the result depends only on the residue.

Decomposition:
- Package crc_stream_pkg holds:
  - the state enum (IDLE, DATA, APPEND)
  - the localparam N_APP = CRC_W/DATA_W
  - a parametrised function crc_step(crc, data) implementing the unrolled bit update
- One sub-module is natural: crc_out_reg, the single-entry valid/ready output register with its hold logic.
- The top level contains the FSM, the CRC register and the append counter.

Test Plan:
- Generate, defaults (INIT=0), single beat 0x01 -> m_data 0x01, then 0x86, 0x4C, 0xFB with m_last on 0xFB; crc_value=0x864CFB; done one pulse.
- Generate, INIT=24'hB704CE, beats "123456789" (0x31..0x39) -> appended 0x21, 0xCF, 0x02; crc_value=0x21CF02.
- Check, INIT=24'hB704CE, "123456789" followed by 0x21, 0xCF, 0x02 -> crc_ok=1 with done. Flip bit 0 of 0x35 -> crc_ok=0.
- Backpressure: m_ready=0 for 5 cycles during APPEND, s_valid held high -> m_data stable, s_ready=0, all 3 CRC beats delivered once in order.
- Back-to-back frames: the second frame's first beat is presented the cycle after done -> second CRC starts from INIT and matches its standalone result.
- Reset mid-append (rstn=0 for 1 cycle after the first CRC beat) -> m_valid=0, done=0 next cycle; the next frame produces correct CRC.
